// File: rtl/delay_line_scheduler_if.sv
// Delay RAM bus plus delayed-output stream of the delay line scheduler.
// The scheduler drives the master side and the RAM/consumer side listens on slave.
interface delay_line_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic              ram_rden;
    logic              ram_wren;
    logic              in_rd;
    logic              out_we;
    logic [ADDR_W-1:0] out_ch;
    logic              out_sel;

    modport master (
        output ram_addr, ram_en, ram_rden, ram_wren,
        output in_rd, out_we, out_ch, out_sel
    );

    modport slave (
        input ram_addr, ram_en, ram_rden, ram_wren,
        input in_rd, out_we, out_ch, out_sel
    );
endinterface

// File: rtl/delay_line_scheduler.sv
// Circular delay RAM sequencer: per step, read then overwrite one slot per channel.
// Define DLY_STA_QUEUE_EN to queue one sta arriving while a step is running.
module delay_line_scheduler #(
    parameter int N_CH        = 8,
    parameter int ADDR_W      = 12,
    parameter int DELAY_STEPS = 16,
    parameter int RD_LAT      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sta,
    delay_line_scheduler_if.master bus,
    output logic busy,
    output logic done,
    output logic overrun
);
    localparam int RING = DELAY_STEPS * N_CH;
    localparam int SC_W = $clog2(DELAY_STEPS + 1);
    localparam int DC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ADDR_W:0]   RING_W  = (ADDR_W+1)'(RING);
    localparam logic [ADDR_W:0]   NCH_W   = (ADDR_W+1)'(N_CH);
    localparam logic [ADDR_W-1:0] CH_LAST = ADDR_W'(N_CH - 1);
    localparam logic [SC_W-1:0]   SC_MAX  = SC_W'(DELAY_STEPS);
    localparam logic [DC_W-1:0]   DC_LAST = DC_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ch_q, ch_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [SC_W-1:0]   step_q, step_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic              sel_q, sel_d;
    logic              ovr_q, ovr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] wep_q, wep_d;
    logic [ADDR_W-1:0] chp_q [RD_LAT];
    logic [ADDR_W-1:0] chp_d [RD_LAT];
`ifdef DLY_STA_QUEUE_EN
    logic              pend_q, pend_d;
`endif

    logic              start;
    logic [ADDR_W:0]   base_nx;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        step_d  = step_q;
        dcnt_d  = dcnt_q;
        sel_d   = sel_q;
        ovr_d   = ovr_q;
        start   = 1'b0;
        base_nx = {1'b0, base_q} + NCH_W;
`ifdef DLY_STA_QUEUE_EN
        pend_d  = pend_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (sta) start = 1'b1;
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    state_d = S_RD;
                    ch_d    = ch_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DC_LAST) state_d = S_DONE;
                else dcnt_d = dcnt_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                base_d  = (base_nx == RING_W) ? '0 : base_nx[ADDR_W-1:0];
                if (step_q != SC_MAX) step_d = step_q + 1'b1;
`ifdef DLY_STA_QUEUE_EN
                // A queued or freshly arriving sta chains straight into RD.
                if (pend_q || sta) start = 1'b1;
                if (pend_q && sta) ovr_d = 1'b1;
                pend_d = 1'b0;
`else
                if (sta) ovr_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (sta && state_q != S_IDLE && state_q != S_DONE) begin
`ifdef DLY_STA_QUEUE_EN
            if (pend_q) ovr_d = 1'b1;
            else pend_d = 1'b1;
`else
            ovr_d = 1'b1;
`endif
        end

        // step_d already holds the post-DONE count when chaining steps
        if (start) begin
            state_d = S_RD;
            ch_d    = '0;
            sel_d   = (step_d == SC_MAX);
        end

        wep_d[0] = rden_q;
        chp_d[0] = rden_q ? ch_q : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            wep_d[i] = wep_q[i-1];
            chp_d[i] = chp_q[i-1];
        end

        if (clr) begin
            state_d = S_IDLE;
            ch_d    = '0;
            base_d  = '0;
            step_d  = '0;
            dcnt_d  = '0;
            sel_d   = 1'b0;
            ovr_d   = 1'b0;
            wep_d   = '0;
            for (int i = 0; i < RD_LAT; i++) chp_d[i] = '0;
`ifdef DLY_STA_QUEUE_EN
            pend_d  = 1'b0;
`endif
        end

        rden_d = (state_d == S_RD);
        wren_d = (state_d == S_WR);
        addr_d = (rden_d || wren_d) ? base_d + ch_d : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            base_q  <= '0;
            step_q  <= '0;
            dcnt_q  <= '0;
            sel_q   <= 1'b0;
            ovr_q   <= 1'b0;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wep_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) chp_q[i] <= '0;
`ifdef DLY_STA_QUEUE_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            base_q  <= base_d;
            step_q  <= step_d;
            dcnt_q  <= dcnt_d;
            sel_q   <= sel_d;
            ovr_q   <= ovr_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wep_q   <= wep_d;
            for (int i = 0; i < RD_LAT; i++) chp_q[i] <= chp_d[i];
`ifdef DLY_STA_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_en   = rden_q | wren_q;
    assign bus.ram_rden = rden_q;
    assign bus.ram_wren = wren_q;
    assign bus.in_rd    = wren_q;
    assign bus.out_we   = wep_q[RD_LAT-1];
    assign bus.out_ch   = chp_q[RD_LAT-1];
    assign bus.out_sel  = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_delay_line_scheduler.sv
// Randomized self-checking bench for delay_line_scheduler against a step-timeline model.
// A second small instance covers the single-channel, single-step-delay corner.
module tb_delay_line_scheduler;
    localparam int N    = 4;
    localparam int DS   = 3;
    localparam int RL   = 2;
    localparam int AW   = 12;
    localparam int RING = N * DS;
    localparam int LAST = 2 * N + RL + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          en;
        logic          rden;
        logic          wren;
        logic          in_rd;
        logic          out_we;
        logic [AW-1:0] out_ch;
        logic          out_sel;
        logic          busy;
        logic          done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic sta = 1'b0;
    logic sta1 = 1'b0;
    logic busy, done, overrun;
    logic busy1, done1, ovr1;

    int checks = 0;
    int failures = 0;
    int m_base;
    int m_cnt;
    bit m_sel;
    int wr_step [RING];

    delay_line_scheduler_if #(.ADDR_W(AW)) bus_a ();
    delay_line_scheduler_if #(.ADDR_W(AW)) bus_b ();

    delay_line_scheduler #(
        .N_CH(N), .ADDR_W(AW), .DELAY_STEPS(DS), .RD_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .sta(sta),
        .bus(bus_a), .busy(busy), .done(done), .overrun(overrun)
    );

    delay_line_scheduler #(
        .N_CH(1), .ADDR_W(AW), .DELAY_STEPS(1), .RD_LAT(RL)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .sta(sta1),
        .bus(bus_b), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        sta = 1'b0;
        sta1 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_base = 0;
        m_cnt = 0;
        m_sel = 1'b0;
    endtask

    function automatic obs_t obs_a();
        obs_t o;
        o.addr    = bus_a.ram_addr;
        o.en      = bus_a.ram_en;
        o.rden    = bus_a.ram_rden;
        o.wren    = bus_a.ram_wren;
        o.in_rd   = bus_a.in_rd;
        o.out_we  = bus_a.out_we;
        o.out_ch  = bus_a.out_ch;
        o.out_sel = bus_a.out_sel;
        o.busy    = busy;
        o.done    = done;
        return o;
    endfunction

    // Expected outputs t cycles after the sta cycle (t=0 means idle).
    function automatic obs_t exp_a(int t, int base, bit sel);
        obs_t e;
        int   r;
        e = '0;
        e.out_sel = sel;
        if (t >= 1 && t <= 2 * N) begin
            e.en   = 1'b1;
            e.addr = AW'(base + (t - 1) / 2);
            if (t % 2 == 1) e.rden = 1'b1;
            else begin
                e.wren  = 1'b1;
                e.in_rd = 1'b1;
            end
        end
        r = t - RL;
        if (r >= 1 && r <= 2 * N - 1 && r % 2 == 1) begin
            e.out_we = 1'b1;
            e.out_ch = AW'((r - 1) / 2);
        end
        e.busy = (t >= 1 && t <= LAST);
        e.done = (t == LAST);
        return e;
    endfunction

    task automatic test_reset();
        obs_t ob;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            ob = obs_a();
            checks++;
            if (ob !== obs_t'(0) || overrun !== 1'b0) begin
                failures++;
                $display("FAIL reset c=%0d got=%h ovr=%b exp=0", c, ob, overrun);
            end
            tick();
        end
    endtask

    task automatic test_single_step();
        obs_t ob, ex;
        int   ndone = 0;
        do_reset();
        sta = 1'b1;
        for (int t = 1; t <= LAST + 2; t++) begin
            tick();
            sta = 1'b0;
            ob = obs_a();
            ex = exp_a(t > LAST ? 0 : t, 0, 1'b0);
            if (ob.done) ndone++;
            checks++;
            if (ob !== ex) begin
                failures++;
                $display("FAIL single t=%0d got=%h exp=%h", t, ob, ex);
            end
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL single_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_random_steps();
        obs_t ob, ex;
        int   gap;
        do_reset();
        for (int a = 0; a < RING; a++) wr_step[a] = -1;
        for (int s = 0; s < 12; s++) begin
            gap = $urandom_range(1, 4);
            repeat (gap) begin
                tick();
                ob = obs_a();
                ex = exp_a(0, m_base, m_sel);
                checks++;
                if (ob !== ex) begin
                    failures++;
                    $display("FAIL rand_idle s=%0d got=%h exp=%h", s, ob, ex);
                end
            end
            m_sel = (m_cnt == DS);
            sta = 1'b1;
            for (int t = 1; t <= LAST; t++) begin
                tick();
                sta = 1'b0;
                ob = obs_a();
                ex = exp_a(t, m_base, m_sel);
                checks++;
                if (ob !== ex) begin
                    failures++;
                    $display("FAIL rand_step s=%0d t=%0d got=%h exp=%h", s, t, ob, ex);
                end
                if (ob.rden && s >= DS && int'(ob.addr) < RING) begin
                    checks++;
                    if (wr_step[ob.addr] != s - DS) begin
                        failures++;
                        $display("FAIL rand_age s=%0d addr=%0d got=%0d exp=%0d",
                                 s, ob.addr, wr_step[ob.addr], s - DS);
                    end
                end
                if (ob.wren && int'(ob.addr) < RING) wr_step[ob.addr] = s;
            end
            m_cnt = (m_cnt < DS) ? m_cnt + 1 : DS;
            m_base = (m_base + N) % RING;
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL rand_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic run_sta_pattern(input bit third, output int nd,
                                   output int d1, output int d2,
                                   output bit rd12, output int a12);
        nd = 0;
        d1 = -1;
        d2 = -1;
        rd12 = 1'b0;
        a12 = -1;
        sta = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            sta = (c == 5) || (third && c == 6);
            if (done) begin
                nd++;
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (c == 12) begin
                rd12 = bus_a.ram_rden;
                a12 = int'(bus_a.ram_addr);
            end
        end
    endtask

    task automatic test_overrun();
        int nd, d1, d2, a12;
        bit rd12;
        do_reset();
        run_sta_pattern(1'b0, nd, d1, d2, rd12, a12);
`ifdef DLY_STA_QUEUE_EN
        checks++;
        if (nd != 2 || d1 != LAST || d2 != 2 * LAST) begin
            failures++;
            $display("FAIL queue_done got=%0d@%0d,%0d exp=2@%0d,%0d",
                     nd, d1, d2, LAST, 2 * LAST);
        end
        checks++;
        if (rd12 !== 1'b1 || a12 != N) begin
            failures++;
            $display("FAIL queue_rd12 got=%b/%0d exp=1/%0d", rd12, a12, N);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL queue_overrun got=%b exp=0", overrun);
        end
        do_reset();
        run_sta_pattern(1'b1, nd, d1, d2, rd12, a12);
        checks++;
        if (overrun !== 1'b1 || nd != 2) begin
            failures++;
            $display("FAIL queue_full got=%b/%0d exp=1/2", overrun, nd);
        end
`else
        checks++;
        if (nd != 1 || d1 != LAST) begin
            failures++;
            $display("FAIL drop_done got=%0d@%0d exp=1@%0d", nd, d1, LAST);
        end
        checks++;
        if (rd12 !== 1'b0) begin
            failures++;
            $display("FAIL drop_rd12 got=%b exp=0", rd12);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL drop_overrun got=%b exp=1", overrun);
        end
`endif
    endtask

    task automatic test_clr();
        int bad = 0;
        sta = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            sta = 1'b0;
            clr = (c == 4);
            if (c >= 5 && (bus_a.out_we || done || busy || overrun)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clr_abort got=%0d busy_cycles exp=0", bad);
        end
        sta = 1'b1;
        tick();
        sta = 1'b0;
        checks++;
        if (bus_a.ram_rden !== 1'b1 || bus_a.ram_addr !== AW'(0)) begin
            failures++;
            $display("FAIL clr_restart got=%b/%h exp=1/0", bus_a.ram_rden, bus_a.ram_addr);
        end
        tick();
        tick();
        checks++;
        if (bus_a.out_we !== 1'b1 || bus_a.out_sel !== 1'b0) begin
            failures++;
            $display("FAIL clr_sel got=%b/%b exp=1/0", bus_a.out_we, bus_a.out_sel);
        end
        repeat (LAST) tick();
    endtask

    task automatic test_async_rst();
        obs_t ob;
        int   nd = 0;
        sta = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            sta = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        ob = obs_a();
        checks++;
        if (ob !== obs_t'(0) || overrun !== 1'b0) begin
            failures++;
            $display("FAIL arst_outputs got=%h exp=0", ob);
        end
        tick();
        rst = 1'b1;
        sta = 1'b1;
        for (int t = 1; t <= LAST; t++) begin
            tick();
            sta = 1'b0;
            ob = obs_a();
            if (ob.done) nd++;
            checks++;
            if (ob !== exp_a(t, 0, 1'b0)) begin
                failures++;
                $display("FAIL arst_restart t=%0d got=%h exp=%h", t, ob, exp_a(t, 0, 1'b0));
            end
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL arst_done got=%0d exp=1", nd);
        end
    endtask

    task automatic test_small();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sta1 = 1'b1;
            for (int t = 1; t <= 6; t++) begin
                tick();
                sta1 = 1'b0;
                checks++;
                if (bus_b.ram_addr !== AW'(0) || done1 !== (t == 5)) begin
                    failures++;
                    $display("FAIL small s=%0d t=%0d got=%h/%b exp=0/%b",
                             s, t, bus_b.ram_addr, done1, t == 5);
                end
                if (t == 3) begin
                    checks++;
                    if (bus_b.out_we !== 1'b1 || bus_b.out_sel !== (s >= 1)) begin
                        failures++;
                        $display("FAIL small_sel s=%0d got=%b/%b exp=1/%b",
                                 s, bus_b.out_we, bus_b.out_sel, s >= 1);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_random_steps();
        test_overrun();
        test_clr();
        test_async_rst();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
